// File: rtl/pivot_pkg.sv
// Shared types and helpers for the sequential pivot search.
// Keys are carried one bit wider than the widest supported element.
package pivot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic MODE_ABS = 1'b1;
  localparam logic MODE_SYM = 1'b1;

  localparam int MAX_W = 32;
  localparam int KEY_W = MAX_W + 1;

  function automatic int n_candidates(
    input int   n,
    input logic sym
  );
    return sym ? (n * (n - 1)) / 2 : n * (n - 1);
  endfunction

  // One extra bit keeps |-2^(W-1)| exact.
  function automatic logic signed [KEY_W-1:0] key_of(
    input logic signed [MAX_W-1:0] value,
    input logic                    abs_mode
  );
    logic signed [KEY_W-1:0] k;
    k = KEY_W'(value);
    if (abs_mode && k[KEY_W-1]) k = -k;
    return k;
  endfunction

endpackage

// File: rtl/pivot_cmp.sv
// Candidate-vs-best comparator for the pivot search.
// Strictly-greater replace keeps the earliest of equal keys.
module pivot_cmp
  import pivot_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] i_val,
  input  logic signed [KEY_W-1:0] i_best_key,
  input  logic                    i_best_vld,
  input  logic                    i_abs,
  output logic                    o_rep,
  output logic signed [KEY_W-1:0] o_key
);

  logic signed [MAX_W-1:0] w_ext;

  assign w_ext = MAX_W'(i_val);
  assign o_key = key_of(w_ext, i_abs);
  assign o_rep = !i_best_vld || (o_key > i_best_key);

endmodule

// File: rtl/pivot_seq_search.sv
// Sequential off-diagonal pivot search, one candidate per clock.
// Walks the matrix row-major without ever landing on the diagonal.
module pivot_seq_search
  import pivot_pkg::*;
#(
  parameter int N_STOCKS = 3,
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abs_mode,
  input  logic                    sym_mode,
  input  logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        pivot_i,
  output logic [IDX_W-1:0]        pivot_j,
  output logic signed [WIDTH-1:0] pivot_val
);

  if (N_STOCKS < 2) begin : g_chk_n
    $error("N_STOCKS must be >= 2");
  end
  if ((2 ** IDX_W) < N_STOCKS) begin : g_chk_idx
    $error("IDX_W too narrow for N_STOCKS");
  end
  if (WIDTH > MAX_W) begin : g_chk_w
    $error("WIDTH exceeds MAX_W");
  end

  localparam int SW     = $clog2(N_STOCKS);
  localparam int IW     = SW + 2;
  localparam int C_FULL = n_candidates(N_STOCKS, 1'b0);
  localparam int C_SYM  = n_candidates(N_STOCKS, 1'b1);
  localparam int CW     = $clog2(C_FULL + 1);

  localparam logic [IW-1:0] NL  = IW'(N_STOCKS);
  localparam logic [IW-1:0] I1  = IW'(1);
  localparam logic [CW-1:0] CF1 = CW'(C_FULL - 1);
  localparam logic [CW-1:0] CS1 = CW'(C_SYM - 1);
  localparam logic [CW-1:0] C1  = CW'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] r_mat;
  logic r_abs;
  logic r_sym;

  logic [SW-1:0] r_i;
  logic [SW-1:0] r_j;
  logic [CW-1:0] r_cnt;

  logic signed [KEY_W-1:0] r_best_key;
  logic                    r_best_vld;
  logic [SW-1:0]           r_bi;
  logic [SW-1:0]           r_bj;
  logic signed [WIDTH-1:0] r_bval;

  logic [SW-1:0]           r_pi;
  logic [SW-1:0]           r_pj;
  logic signed [WIDTH-1:0] r_pval;

  logic signed [WIDTH-1:0] w_val;
  logic signed [KEY_W-1:0] w_key;
  logic                    w_rep;
  logic                    w_last;
  logic [IW-1:0]           w_in;
  logic [IW-1:0]           w_jn;

  assign w_val = r_mat[r_i][r_j];

  pivot_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .i_val     (w_val),
    .i_best_key(r_best_key),
    .i_best_vld(r_best_vld),
    .i_abs     (r_abs == MODE_ABS),
    .o_rep     (w_rep),
    .o_key     (w_key)
  );

  // Next candidate: hop over the diagonal, wrap rows.
  always_comb begin
    w_in = IW'(r_i);
    w_jn = IW'(r_j) + I1;
    if (r_sym != MODE_SYM && w_jn == IW'(r_i))
      w_jn = w_jn + I1;
    if (w_jn >= NL) begin
      w_in = IW'(r_i) + I1;
      w_jn = (r_sym == MODE_SYM) ? w_in + I1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = SCAN;
      SCAN: begin
        w_last = (r_cnt == '0);
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_abs      <= 1'b0;
      r_sym      <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_cnt      <= '0;
      r_best_key <= '0;
      r_best_vld <= 1'b0;
      r_bi       <= '0;
      r_bj       <= '0;
      r_bval     <= '0;
      r_pi       <= '0;
      r_pj       <= '0;
      r_pval     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && start) begin
        r_mat      <= matrix;
        r_abs      <= abs_mode;
        r_sym      <= sym_mode;
        r_i        <= '0;
        r_j        <= SW'(1);
        r_cnt      <= sym_mode ? CS1 : CF1;
        r_best_vld <= 1'b0;
      end
      if (r_state == SCAN) begin
        if (w_rep) begin
          r_best_key <= w_key;
          r_best_vld <= 1'b1;
          r_bi       <= r_i;
          r_bj       <= r_j;
          r_bval     <= w_val;
        end
        r_i   <= w_in[SW-1:0];
        r_j   <= w_jn[SW-1:0];
        r_cnt <= r_cnt - C1;
        // Last candidate still competes on the DONE entry edge.
        if (w_last) begin
          r_pi   <= w_rep ? r_i : r_bi;
          r_pj   <= w_rep ? r_j : r_bj;
          r_pval <= w_rep ? w_val : r_bval;
        end
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign pivot_i   = IDX_W'(r_pi);
  assign pivot_j   = IDX_W'(r_pj);
  assign pivot_val = r_pval;

endmodule

// File: tb/tb_pivot_seq_search.sv
// Directed and randomized bench for pivot_seq_search.
// Expected results are queued at start and popped on done.
module tb_pivot_seq_search;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int IW = 4;

  typedef logic signed [N-1:0][N-1:0][W-1:0] mat_t;

  typedef struct {
    int           i;
    int           j;
    logic [W-1:0] v;
    int           lat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abs_mode;
  logic                 sym_mode;
  mat_t                 matrix;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        pivot_i;
  logic [IW-1:0]        pivot_j;
  logic signed [W-1:0]  pivot_val;

  exp_t         sb[$];
  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] prev_val    = '0;

  always #5 clk = ~clk;

  pivot_seq_search #(
    .N_STOCKS(N),
    .WIDTH   (W),
    .IDX_W   (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abs_mode (abs_mode),
    .sym_mode (sym_mode),
    .matrix   (matrix),
    .busy     (busy),
    .done     (done),
    .pivot_i  (pivot_i),
    .pivot_j  (pivot_j),
    .pivot_val(pivot_val)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t mk(
    input logic [W-1:0] a00, a01, a02,
    input logic [W-1:0] a10, a11, a12,
    input logic [W-1:0] a20, a21, a22
  );
    mat_t m;
    m[0][0] = a00; m[0][1] = a01; m[0][2] = a02;
    m[1][0] = a10; m[1][1] = a11; m[1][2] = a12;
    m[2][0] = a20; m[2][1] = a21; m[2][2] = a22;
    return m;
  endfunction

  // Reference: plain integer keys, row-major walk.
  function automatic void model(
    input  mat_t         m,
    input  bit           a,
    input  bit           s,
    output int           bi,
    output int           bj,
    output logic [W-1:0] bv
  );
    int best;
    int k;
    int v;
    bit vld;
    logic signed [W-1:0] e;
    vld = 0; best = 0; bi = 0; bj = 0; bv = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i == j || (s && j < i)) continue;
        e = m[i][j];
        v = e;
        k = (a && v < 0) ? -v : v;
        if (!vld || k > best) begin
          vld = 1; best = k; bi = i; bj = j; bv = e;
        end
      end
    end
  endfunction

  task automatic run(
    input mat_t         m,
    input bit           a,
    input bit           s,
    input int           ei,
    input int           ej,
    input logic [W-1:0] ev,
    input bit           disturb,
    input string        tag
  );
    exp_t e;
    int   cyc;
    int   extra;
    e.i   = ei;
    e.j   = ej;
    e.v   = ev;
    e.lat = (s ? (N * (N - 1)) / 2 : N * (N - 1)) + 1;
    sb.push_back(e);
    @(negedge clk);
    matrix   = m;
    abs_mode = a;
    sym_mode = s;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    chk({tag, "/busy"}, 64'(busy), 64'd1);
    chk({tag, "/hold"}, 64'($unsigned(pivot_val)), 64'(prev_val));
    while (!done && cyc < 40) begin
      if (disturb && cyc == 2) begin
        start    = 1'b1;
        matrix   = ~m;
        abs_mode = ~a;
        sym_mode = ~s;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "/done"}, 64'(done), 64'd1);
    e = sb.pop_front();
    chk({tag, "/latency"}, 64'(cyc), 64'(e.lat));
    chk({tag, "/pivot_i"}, 64'(pivot_i), 64'(e.i));
    chk({tag, "/pivot_j"}, 64'(pivot_j), 64'(e.j));
    chk({tag, "/pivot_val"}, 64'($unsigned(pivot_val)), 64'(e.v));
    prev_val = e.v;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk({tag, "/single_done"}, 64'(extra), 64'd0);
    chk({tag, "/idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    mat_t         m1, m2, m3, mt, mt2, rm;
    int           bi, bj, extra;
    logic [W-1:0] bv;
    logic [W-1:0] pool [4];
    int           idx;

    pool[0] = 16'h8000;
    pool[1] = 16'h7fff;
    pool[2] = 16'hffff;
    pool[3] = 16'h0000;

    rst      = 1'b1;
    start    = 1'b0;
    abs_mode = 1'b0;
    sym_mode = 1'b0;
    matrix   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/pivot_i", 64'(pivot_i), 64'd0);
    chk("reset/pivot_j", 64'(pivot_j), 64'd0);
    chk("reset/pivot_val", 64'($unsigned(pivot_val)), 64'd0);
    rst = 1'b0;

    m1 = mk(16'h020, 16'h080, 16'h020,
            16'h110, 16'h400, 16'h004,
            16'h430, 16'h440, 16'h400);
    run(m1, 0, 0, 2, 1, 16'h0440, 0, "s1_signed");

    m2 = mk(16'h0400, 16'h1000, 16'h8400,
            16'h2200, 16'h8000, 16'h0080,
            16'h8600, 16'h8800, 16'h8000);
    run(m2, 0, 0, 1, 0, 16'h2200, 0, "s2_signed");
    run(m2, 1, 0, 0, 2, 16'h8400, 0, "s3_abs");

    m3 = m2;
    m3[1][2] = 16'h8000;
    run(m3, 1, 0, 1, 2, 16'h8000, 0, "s3_abs_min");

    run(m2, 0, 1, 0, 1, 16'h1000, 0, "s4_sym_signed");
    run(m2, 1, 1, 0, 2, 16'h8400, 0, "s4_sym_abs");

    run('0, 0, 0, 0, 1, 16'h0000, 0, "s5_zero");
    run('0, 1, 1, 0, 1, 16'h0000, 0, "s5_zero_sym_abs");

    mt = mk(16'h0000, 16'h0000, 16'h0000,
            16'h0100, 16'h0000, 16'h0000,
            16'h0000, 16'h0100, 16'h0000);
    run(mt, 0, 0, 1, 0, 16'h0100, 0, "s5_tie");
    mt2 = mt;
    mt2[0][2] = 16'hff00;
    run(mt2, 1, 0, 0, 2, 16'hff00, 0, "s5_tie_abs");
    run(mt2, 0, 0, 1, 0, 16'h0100, 0, "s5_tie_signed");

    run(m1, 0, 0, 2, 1, 16'h0440, 1, "s6_restart");

    @(negedge clk);
    matrix = m2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("s6_rst/busy", 64'(busy), 64'd0);
    chk("s6_rst/done", 64'(done), 64'd0);
    chk("s6_rst/pivot_i", 64'(pivot_i), 64'd0);
    chk("s6_rst/pivot_j", 64'(pivot_j), 64'd0);
    chk("s6_rst/pivot_val", 64'($unsigned(pivot_val)), 64'd0);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("s6_rst/no_done", 64'(extra), 64'd0);
    prev_val = '0;
    run(m2, 0, 0, 1, 0, 16'h2200, 0, "s6_after_rst");

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          idx = $urandom_range(0, 5);
          rm[i][j] = (idx < 4) ? pool[idx] : W'($urandom);
        end
      end
      model(rm, t[0], t[1], bi, bj, bv);
      run(rm, t[0], t[1], bi, bj, bv, t[2], $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
